// File: rtl/decoder_scan_sequencer_pkg.sv
// Shared types and constants for the decoder scan sequencer and its channel search helper.
package decoder_scan_sequencer_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   localparam int unsigned CODE_W = 3;
   localparam int unsigned NUM_CH = 8;
   localparam logic [NUM_CH-1:0] ALL_MASKED = 8'hFF;

endpackage

// File: rtl/decoder_scan_sequencer_next_channel.sv
// Combinational search for the next / first unmasked channel of an 8-channel scan.
module scan_next_channel
   import decoder_scan_sequencer_pkg::*;
(
   input  logic [CODE_W-1:0] cur,
   input  logic [NUM_CH-1:0] mask,
   output logic [CODE_W-1:0] next,
   output logic [CODE_W-1:0] first,
   output logic              wrap,
   output logic              none
);

   // Walk from the top index down so the lowest qualifying channel is written last.
   always_comb begin
      next  = '0;
      first = '0;
      wrap  = 1'b1;
      none  = (mask == ALL_MASKED);
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (!mask[NUM_CH-1-i]) begin
            first = CODE_W'(NUM_CH-1-i);
            if ((NUM_CH-1-i) > int'(cur)) begin
               next = CODE_W'(NUM_CH-1-i);
               wrap = 1'b0;
            end
         end
      end
   end

endmodule

// File: rtl/decoder_scan_sequencer.sv
// Scan sequencer driving the {A,B,C} select of a 3-to-8 decoder with per-channel dwell,
// channel skipping, one-shot / continuous sweeps and a graceful stop.
module decoder_scan_sequencer
   import decoder_scan_sequencer_pkg::*;
#(
   parameter int unsigned DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               mode,
   input  logic               stop,
   input  logic [DWELL_W-1:0] dwell,
   input  logic [NUM_CH-1:0]  skip_mask,
   output logic               A,
   output logic               B,
   output logic               C,
   output logic               sel_valid,
   output logic               busy,
   output logic               chan_strobe,
   output logic               sweep_done
);

   state_t              state, state_nxt;
   logic [CODE_W-1:0]   code, code_nxt;
   logic [DWELL_W-1:0]  cnt, cnt_nxt;
   logic [DWELL_W-1:0]  dwell_q, dwell_q_nxt;
   logic [NUM_CH-1:0]   mask_q, mask_q_nxt;
   logic                mode_q, mode_q_nxt;
   logic                stop_pend, stop_pend_nxt;
   logic                sel_valid_nxt, busy_nxt, sweep_done_nxt;

   logic [CODE_W-1:0]   cur_next, cur_first_unused;
   logic                cur_wrap, cur_none_unused;
   logic [CODE_W-1:0]   live_first, live_next_unused;
   logic                live_none, live_wrap_unused;

   // Two searches: stepping uses the latched mask, while sweep starts and continuous
   // wraps need the first channel of the live skip_mask sampled on that same edge.
   scan_next_channel u_cur (
      .cur   (code),
      .mask  (mask_q),
      .next  (cur_next),
      .first (cur_first_unused),
      .wrap  (cur_wrap),
      .none  (cur_none_unused)
   );

   scan_next_channel u_live (
      .cur   ('0),
      .mask  (skip_mask),
      .next  (live_next_unused),
      .first (live_first),
      .wrap  (live_wrap_unused),
      .none  (live_none)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         code       <= '0;
         cnt        <= '0;
         dwell_q    <= '0;
         mask_q     <= '0;
         mode_q     <= 1'b0;
         stop_pend  <= 1'b0;
         sel_valid  <= 1'b0;
         busy       <= 1'b0;
         sweep_done <= 1'b0;
      end else begin
         code       <= code_nxt;
         cnt        <= cnt_nxt;
         dwell_q    <= dwell_q_nxt;
         mask_q     <= mask_q_nxt;
         mode_q     <= mode_q_nxt;
         stop_pend  <= stop_pend_nxt;
         sel_valid  <= sel_valid_nxt;
         busy       <= busy_nxt;
         sweep_done <= sweep_done_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      code_nxt       = code;
      cnt_nxt        = cnt;
      dwell_q_nxt    = dwell_q;
      mask_q_nxt     = mask_q;
      mode_q_nxt     = mode_q;
      stop_pend_nxt  = stop_pend;
      sel_valid_nxt  = sel_valid;
      busy_nxt       = busy;
      sweep_done_nxt = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) begin
               mode_q_nxt  = mode;
               dwell_q_nxt = dwell;
               mask_q_nxt  = skip_mask;
               if (live_none) begin
                  sweep_done_nxt = 1'b1;
               end else begin
                  code_nxt      = live_first;
                  cnt_nxt       = dwell;
                  sel_valid_nxt = 1'b1;
                  busy_nxt      = 1'b1;
                  state_nxt     = SCAN;
               end
            end
         end
         SCAN: begin
            if (stop) stop_pend_nxt = 1'b1;
            if (cnt != '0) begin
               cnt_nxt = cnt - DWELL_W'(1);
            end else if (!cur_wrap) begin
               code_nxt = cur_next;
               cnt_nxt  = dwell_q;
            end else begin
               sweep_done_nxt = 1'b1;
               // A stop arriving on the wrap edge itself still ends the scan here.
               if (mode_q && !stop_pend && !stop && !live_none) begin
                  dwell_q_nxt = dwell;
                  mask_q_nxt  = skip_mask;
                  code_nxt    = live_first;
                  cnt_nxt     = dwell;
               end else begin
                  state_nxt     = IDLE;
                  code_nxt      = '0;
                  sel_valid_nxt = 1'b0;
                  busy_nxt      = 1'b0;
                  stop_pend_nxt = 1'b0;
               end
            end
         end
      endcase
   end

   always_comb begin
      chan_strobe = (state == SCAN) && (cnt == '0);
      A           = code[2];
      B           = code[1];
      C           = code[0];
   end

endmodule

// File: doc/decoder_scan_sequencer.md
Name: decoder_scan_sequencer

Overview:
- Sequential stage directly upstream of the team's 3-to-8 decoder.
- Produces the 3-bit select code {A,B,C}, stepping through channels 0..7, so the decoder's one-hot output scans 8 rows/digits.
- Each channel is held for a programmable dwell time; masked channels are skipped.
- Supports one-shot and continuous sweeps, a graceful stop, and per-channel and end-of-sweep status pulses.

Parameters:
- DWELL_W, 8, width of the dwell input and the internal dwell counter.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  request a sweep; sampled only in IDLE.
- mode  in  1  0 = one-shot sweep, 1 = continuous sweeps.
- stop  in  1  ends continuous scanning after the current sweep.
- dwell  in  DWELL_W  each channel is held for dwell+1 cycles.
- skip_mask  in  8  bit i = 1 skips channel i.
- A  out  1  select MSB (code bit 2), driven to the decoder's A input.
- B  out  1  select bit 1.
- C  out  1  select LSB (code bit 0).
- sel_valid  out  1  {A,B,C} is an active channel.
- busy  out  1  a sweep is in progress.
- chan_strobe  out  1  high in the final dwell cycle of the current channel.
- sweep_done  out  1  one-cycle pulse after the last channel of a sweep.

Behaviour:
- The code is {A,B,C} = channel index, with A as MSB. All outputs are registered, except chan_strobe, which is decoded from registered state (state==SCAN && cnt==0).
- Synchronous reset (rst_n = 0 at a clk edge):
  - state = IDLE; {A,B,C} = 000; sel_valid, busy, sweep_done = 0; cnt = 0; stop_pend = 0.
  - chan_strobe is 0 as a consequence.
  - Reset in mid-sweep aborts immediately; no sweep_done is issued.
- State IDLE:
  - On an edge with start = 1, latch mode, dwell and skip_mask.
  - If the latched mask is 8'hFF: remain IDLE, pulse sweep_done in the next cycle, and keep sel_valid at 0.
  - Otherwise: code <= lowest unmasked index; cnt <= dwell; sel_valid <= 1; busy <= 1; state <= SCAN.
  - Latency: sel_valid rises in the cycle after start is sampled.
- State SCAN:
  - start is ignored.
  - stop = 1 on any edge sets stop_pend.
  - When cnt != 0, cnt decrements each cycle.
  - When cnt == 0 and a higher unmasked index exists: code <= that index; cnt <= latched dwell.
  - When cnt == 0 and the current index is the highest unmasked one (wrap): sweep_done <= 1 for exactly one cycle.
- Wrap, continuous mode with stop_pend = 0:
  - Re-sample dwell and skip_mask.
  - code <= lowest unmasked index; cnt <= dwell; stay in SCAN with no gap cycle.
  - If the re-sampled mask is 8'hFF, treat the wrap as the terminal case below.
- Wrap, terminal case (one-shot mode, stop_pend = 1, or all channels masked):
  - state <= IDLE; code <= 000; sel_valid <= 0; busy <= 0; stop_pend <= 0.
- Boundaries:
  - dwell = 0 gives one cycle per channel.
  - dwell = max gives 2^DWELL_W cycles per channel.
  - A single unmasked channel wraps to itself each sweep.
  - stop while IDLE has no effect.
  - stop asserted on the same edge as a wrap takes effect at that wrap.
  - skip_mask and dwell changes mid-sweep are ignored until the next sample point.
- Sweep length = (number of unmasked channels) × (dwell+1) cycles.

Decomposition:
- Shared include file scan_defs.vh:
  - state encodings IDLE = 1'b0, SCAN = 1'b1
  - CODE_W = 3
  - NUM_CH = 8
  - ALL_MASKED = 8'hFF
- Sub-module scan_next_channel (purely combinational).
  - Inputs: cur[2:0], mask[7:0].
  - Outputs: next[2:0] (lowest unmasked index above cur), first[2:0] (lowest unmasked index overall), wrap (no unmasked index above cur), none (mask == 8'hFF).
- Top level holds the FSM, dwell counter, stop_pend and output registers.

Test Plan:
- Reset: hold rst_n = 0 for 2 edges with start = 1 -> A,B,C = 0, sel_valid = 0, busy = 0, sweep_done = 0, chan_strobe = 0.
- One-shot, dwell = 2, mask = 8'h00, start pulsed at cycle 0:
  - Codes 000..111 in order, each held 3 cycles from cycle 1; chan_strobe fires on each third cycle.
  - sweep_done = 1 at cycle 25; busy = 0 from cycle 25.
- Skip test, dwell = 0, mask = 8'b1010_0101: code sequence is exactly 1, 3, 4, 6 (one cycle each), then the sweep_done pulse and return to IDLE.
- Continuous, dwell = 0, mask = 8'h00, with stop = 1 for one cycle while code = 3 and start = 1 pulsed mid-sweep:
  - Codes continue 4..7; then sweep_done and IDLE.
  - start has no effect.
- All masked, mask = 8'hFF, start pulsed -> sweep_done pulses next cycle; sel_valid and busy stay 0.
- Reset mid-sweep: rst_n = 0 while code = 5 -> next edge gives all reset values and no sweep_done pulse; a later start restarts from channel 0.
